// File: rtl/shared_reg_pkg.sv
// Shared definitions for the shared-register arbiter slice.
// State encoding and writer-id width helper.
package shared_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic int calc_idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req bit at or above ptr.
// Ports: req, ptr in; grant (one-hot), sel (index), any out.
module rr_picker
  import shared_reg_pkg::*;
#(
  parameter  int N_WR = 2,
  localparam int IDW  = calc_idw(N_WR)
) (
  input  logic [N_WR-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [N_WR-1:0] grant,
  output logic [IDW-1:0]  sel,
  output logic            any
);

  logic [IDW-1:0] idx;

  always_comb begin
    grant = '0;
    sel   = '0;
    any   = 1'b0;
    idx   = '0;
    for (int o = 0; o < N_WR; o++) begin
      idx = IDW'((int'(ptr) + o) % N_WR);
      if (!any && req[idx]) begin
        any        = 1'b1;
        sel        = idx;
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Serialises writes from N_WR writers into one shared register (round-robin).
// Ports: clk, rst, wr_req, wr_data in; wr_ack, q, q_valid, last_id,
// conflict_cnt, busy out. All outputs are registered or decoded from state.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter  int N_WR     = 2,
  parameter  int DW       = 1,
  parameter  int CNT_W    = 8,
  parameter  int HOLD_CYC = 0,
  localparam int IDW      = calc_idw(N_WR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_WR-1:0]    wr_req,
  input  logic [N_WR*DW-1:0] wr_data,
  output logic [N_WR-1:0]    wr_ack,
  output logic [DW-1:0]      q,
  output logic               q_valid,
  output logic [IDW-1:0]     last_id,
  output logic [CNT_W-1:0]   conflict_cnt,
  output logic               busy
);

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam logic [HW-1:0] HOLD_LAST =
    HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

  state_t         state;
  state_t         state_nx;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nx;
  logic [HW-1:0]  hold_cnt;
  logic           hold_done;

  logic [N_WR-1:0] pk_grant;
  logic [IDW-1:0]  pk_sel;
  logic            pk_any;
  logic            grant_en;
  logic            multi;
  logic [DW-1:0]   pick_data;

  rr_picker #(
    .N_WR (N_WR)
  ) u_pick (
    .req   (wr_req),
    .ptr   (ptr),
    .grant (pk_grant),
    .sel   (pk_sel),
    .any   (pk_any)
  );

  assign grant_en  = (state == IDLE) && pk_any;
  assign hold_done = (hold_cnt == HOLD_LAST);

  // x & (x-1) clears the lowest set bit: nonzero iff 2+ bits set.
  assign multi = |(wr_req & (wr_req - N_WR'(1)));

  assign ptr_nx = (pk_sel == IDW'(N_WR - 1)) ? '0 : pk_sel + IDW'(1);

  // Only the granted writer's data reaches the register.
  always_comb begin
    pick_data = '0;
    for (int i = 0; i < N_WR; i++) begin
      if (pk_sel == IDW'(i)) pick_data = wr_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pk_any) state_nx = ACK;
      ACK:     state_nx = (HOLD_CYC > 0) ? HOLD : IDLE;
      HOLD:    if (hold_done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q            <= '0;
      q_valid      <= 1'b0;
      wr_ack       <= '0;
      last_id      <= '0;
      conflict_cnt <= '0;
      ptr          <= '0;
      hold_cnt     <= '0;
    end else begin
      wr_ack <= '0;
      if (state == HOLD) hold_cnt <= hold_cnt + HW'(1);
      else               hold_cnt <= '0;
      if (grant_en) begin
        q       <= pick_data;
        wr_ack  <= pk_grant;
        last_id <= pk_sel;
        q_valid <= 1'b1;
        ptr     <= ptr_nx;
        if (multi && (conflict_cnt != '1))
          conflict_cnt <= conflict_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: two configurations against a cycle model.
// A: N_WR=2 DW=1 CNT_W=2 HOLD=0; B: N_WR=3 DW=4 CNT_W=8 HOLD=3.
module tb_shared_reg_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [1:0] req_a, data_a, ack_a, cnt_a;
  logic [0:0] q_a, last_a;
  logic       qv_a, busy_a;

  logic [2:0]  req_b, ack_b;
  logic [11:0] data_b;
  logic [3:0]  q_b;
  logic [1:0]  last_b;
  logic [7:0]  cnt_b;
  logic        qv_b, busy_b;

  shared_reg_arbiter #(
    .N_WR(2), .DW(1), .CNT_W(2), .HOLD_CYC(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .wr_req(req_a), .wr_data(data_a),
    .wr_ack(ack_a), .q(q_a), .q_valid(qv_a), .last_id(last_a),
    .conflict_cnt(cnt_a), .busy(busy_a)
  );

  shared_reg_arbiter #(
    .N_WR(3), .DW(4), .CNT_W(8), .HOLD_CYC(3)
  ) dut_b (
    .clk(clk), .rst(rst_b), .wr_req(req_b), .wr_data(data_b),
    .wr_ack(ack_b), .q(q_b), .q_valid(qv_b), .last_id(last_b),
    .conflict_cnt(cnt_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: a cooldown counter of cycles before the next
  // request may be sampled, plus the architectural register contents.
  int m_n[2]    = '{2, 3};
  int m_dw[2]   = '{1, 4};
  int m_hold[2] = '{0, 3};
  int m_cmax[2] = '{3, 255};
  int m_q[2], m_qv[2], m_ack[2], m_last[2], m_cnt[2], m_ptr[2], m_cool[2];

  task automatic model(input int k, input logic rst,
                       input logic [2:0] req, input logic [11:0] data);
    int n, sel, pc, idx;
    n = m_n[k];
    sel = -1;
    pc = 0;
    for (int i = 0; i < n; i++) pc += int'(req[i]);
    if (rst) begin
      m_q[k] = 0; m_qv[k] = 0; m_ack[k] = 0; m_last[k] = 0;
      m_cnt[k] = 0; m_ptr[k] = 0; m_cool[k] = 0;
    end else if (m_cool[k] == 0 && pc > 0) begin
      for (int o = 0; o < n; o++) begin
        idx = (m_ptr[k] + o) % n;
        if (sel < 0 && req[idx]) sel = idx;
      end
      m_q[k]    = int'(data >> (sel * m_dw[k])) & ((1 << m_dw[k]) - 1);
      m_ack[k]  = 1 << sel;
      m_last[k] = sel;
      m_qv[k]   = 1;
      m_ptr[k]  = (sel + 1) % n;
      if (pc > 1 && m_cnt[k] < m_cmax[k]) m_cnt[k]++;
      m_cool[k] = 1 + m_hold[k];
    end else begin
      m_ack[k] = 0;
      if (m_cool[k] > 0) m_cool[k]--;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model(0, rst_a, {1'b0, req_a}, {10'b0, data_a});
    model(1, rst_b, req_b, data_b);
    #1;
    check("A.q", q_a, m_q[0]);
    check("A.qv", qv_a, m_qv[0]);
    check("A.ack", ack_a, m_ack[0]);
    check("A.last", last_a, m_last[0]);
    check("A.cnt", cnt_a, m_cnt[0]);
    check("A.busy", busy_a, m_cool[0] > 0);
    check("B.q", q_b, m_q[1]);
    check("B.qv", qv_b, m_qv[1]);
    check("B.ack", ack_b, m_ack[1]);
    check("B.last", last_b, m_last[1]);
    check("B.cnt", cnt_b, m_cnt[1]);
    check("B.busy", busy_b, m_cool[1] > 0);
  endtask

  task automatic writers(input int n, input int dw, input logic [2:0] ack,
                         inout logic [2:0] req, inout logic [11:0] data);
    for (int i = 0; i < n; i++) begin
      if (ack[i]) begin
        req[i] = 1'b0;
      end else if (req[i]) begin
        if ($urandom_range(0, 19) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
        for (int b = 0; b < dw; b++) data[i*dw+b] = 1'($urandom_range(0, 1));
      end
    end
  endtask

  int g, prev, first, nacks, nbusy;
  logic [2:0]  ra;
  logic [11:0] da;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_q[k] = 0; m_qv[k] = 0; m_ack[k] = 0; m_last[k] = 0;
      m_cnt[k] = 0; m_ptr[k] = 0; m_cool[k] = 0;
    end
    rst_a = 1'b1; rst_b = 1'b1;
    req_a = 2'($urandom); data_a = 2'($urandom);
    req_b = 3'($urandom); data_b = 12'($urandom);

    // reset with random requests
    step();
    req_a = 2'($urandom); req_b = 3'($urandom);
    step();
    check("rst.q", q_a, 0);
    check("rst.qv", qv_a, 0);
    check("rst.ack", ack_a, 0);
    check("rst.last", last_a, 0);
    check("rst.cnt", cnt_a, 0);
    check("rst.busy", busy_a, 0);

    // single writer
    rst_a = 1'b0; req_b = '0;
    req_a = 2'b01; data_a = 2'b01;
    step();
    check("single.q", q_a, 1);
    check("single.ack", ack_a, 2'b01);
    check("single.last", last_a, 0);
    check("single.qv", qv_a, 1);
    check("single.cnt", cnt_a, 0);
    req_a = 2'b00;
    step();
    check("single.ack_off", ack_a, 0);

    // collision from ptr=0
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
    req_a = 2'b11; data_a = 2'b10;
    step();
    check("coll.q0", q_a, 0);
    check("coll.last0", last_a, 0);
    check("coll.cnt0", cnt_a, 1);
    req_a = 2'b10;
    step();
    step();
    check("coll.q1", q_a, 1);
    check("coll.last1", last_a, 1);
    check("coll.ack1", ack_a, 2'b10);
    check("coll.cnt1", cnt_a, 1);
    req_a = 2'b00;
    step();

    // fairness under continuous contention
    req_a = 2'b11; data_a = 2'b11;
    g = 0;
    for (int c = 0; c < 40 && g < 8; c++) begin
      step();
      if (ack_a != 0) begin
        check("fair.last", last_a, g % 2);
        g++;
      end
    end
    check("fair.grants", g, 8);
    check("sat.cnt", cnt_a, 3);

    // reset during ACK
    req_a = 2'b00;
    step();
    step();
    req_a = 2'b11;
    step();
    check("midack.ack", ack_a != 0, 1);
    req_a = 2'b00; rst_a = 1'b1;
    step();
    check("midack.ack0", ack_a, 0);
    check("midack.q0", q_a, 0);
    check("midack.cnt0", cnt_a, 0);
    rst_a = 1'b0;

    // hold period on B
    rst_b = 1'b0; req_b = 3'b111; data_b = 12'($urandom);
    prev = -1; first = -1; nacks = 0; nbusy = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (ack_b != 0) begin
        if (prev >= 0) check("hold.period", c - prev, 5);
        prev = c;
        if (first < 0) first = c;
      end
      if (first >= 0 && c < first + 20) begin
        nbusy += int'(busy_b);
        nacks += int'(ack_b != 0);
      end
    end
    check("hold.busy", nbusy, 16);
    check("hold.acks", nacks, 4);

    // random writers on both
    req_a = '0; req_b = '0;
    for (int c = 0; c < 600; c++) begin
      ra = {1'b0, req_a}; da = {10'b0, data_a};
      writers(2, 1, {1'b0, ack_a}, ra, da);
      req_a = ra[1:0]; data_a = da[1:0];
      ra = req_b; da = data_b;
      writers(3, 4, ack_b, ra, da);
      req_b = ra; data_b = da;
      rst_a = ($urandom_range(0, 99) == 0);
      rst_b = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
